// File: rtl/csa_group_accumulator.sv
// Groups a stream of 10-bit operands into passes of up to eight, reduces each pass with a
// carry-save tree, resolves it with one carry-propagate add, and accumulates the group total.
module csa_group_accumulator #(
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [9:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        COMPRESS = 2'd1,
        ACCUM    = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [7:0][9:0]  slots_q, slots_d;
    logic [2:0]       idx_q, idx_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             last_q, last_d;
    logic [12:0]      cs_a_q, cs_a_d;
    logic [12:0]      cs_b_q, cs_b_d;
    logic [12:0]      out1_s, out2_s;
    logic [13:0]      pass_s;
    logic [ACC_W:0]   acc_sum_s;

    // One 3:2 compressor level: returns {sum vector, carry vector}.
    function automatic logic [25:0] csa3(input logic [12:0] a, input logic [12:0] b,
                                         input logic [12:0] c);
        logic [12:0] s;
        logic [12:0] cy;
        s  = a ^ b ^ c;
        cy = ((a & b) | (a & c) | (b & c)) << 1'b1;
        return {s, cy};
    endfunction

    // Carry-save tree: eight slots plus the constant 4, so out1 + out2 = sum + 4 (mod 2^13).
    always_comb begin : csa_tree
        logic [12:0] s1, c1, s2, c2, s3, c3, s4, c4, s5, c5, s6, c6;
        {s1, c1}         = csa3({3'b000, slots_q[0]}, {3'b000, slots_q[1]}, {3'b000, slots_q[2]});
        {s2, c2}         = csa3({3'b000, slots_q[3]}, {3'b000, slots_q[4]}, {3'b000, slots_q[5]});
        {s3, c3}         = csa3({3'b000, slots_q[6]}, {3'b000, slots_q[7]}, 13'd4);
        {s4, c4}         = csa3(s1, c1, s2);
        {s5, c5}         = csa3(c2, s3, c3);
        {s6, c6}         = csa3(s4, c4, s5);
        {out1_s, out2_s} = csa3(s6, c6, c5);
    end

    // The pass total never exceeds 8184, so resolving it modulo 2^13 is exact.
    assign pass_s    = {1'b0, 13'(cs_a_q + cs_b_q - 13'd4)};
    assign acc_sum_s = {1'b0, acc_q} + {{(ACC_W - 13){1'b0}}, pass_s};

    assign in_ready  = (state_q == COLLECT) && !rst;
    assign out_valid = (state_q == DONE);
    assign out_sum   = acc_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;
    assign busy      = !((state_q == COLLECT) && (idx_q == 3'd0) && (acc_q == '0));

    // Next-state and datapath update for the collect/compress/accumulate/present sequence.
    always_comb begin
        state_d = state_q;
        slots_d = slots_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        last_d  = last_q;
        cs_a_d  = cs_a_q;
        cs_b_d  = cs_b_q;
        case (state_q)
            COLLECT: begin
                if (in_valid && in_ready) begin
                    slots_d[idx_q] = in_data;
                    idx_d          = idx_q + 3'd1;
                    cnt_d          = cnt_q + {{(CNT_W - 1){1'b0}}, 1'b1};
                    last_d         = in_last;
                    if ((idx_q == 3'd7) || in_last) begin
                        state_d = COMPRESS;
                    end else begin
                        state_d = COLLECT;
                    end
                end else begin
                    state_d = COLLECT;
                end
            end
            COMPRESS: begin
                cs_a_d  = out1_s;
                cs_b_d  = out2_s;
                state_d = ACCUM;
            end
            ACCUM: begin
                acc_d   = acc_sum_s[ACC_W-1:0];
                ovf_d   = ovf_q | acc_sum_s[ACC_W];
                slots_d = '0;
                idx_d   = 3'd0;
                if (last_q) begin
                    state_d = DONE;
                end else begin
                    state_d = COLLECT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = COLLECT;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // State and datapath registers; reset abandons any group in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
            slots_q <= '0;
            idx_q   <= 3'd0;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            last_q  <= 1'b0;
            cs_a_q  <= 13'd0;
            cs_b_q  <= 13'd0;
        end else begin
            state_q <= state_d;
            slots_q <= slots_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            last_q  <= last_d;
            cs_a_q  <= cs_a_d;
            cs_b_q  <= cs_b_d;
        end
    end

endmodule

// File: tb/tb_csa_group_accumulator.sv
// Randomized self-checking bench for csa_group_accumulator: group sums come from plain
// integer arithmetic over the operand list and are compared against each presented result.
`timescale 1ns/1ps
module tb_csa_group_accumulator;

    localparam int ACC_W = 16;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [9:0]       in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;
    int unsigned beats[$];

    csa_group_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sends the operands in 'beats' as one group and consumes its result.
    // Called and returns on a falling edge.
    task automatic play(input int in_stall, input int out_stall, input int hold);
        int      i          = 0;
        int      pos        = 0;
        int      guard      = 0;
        int      cyc        = 0;
        int      last_cyc   = -1;
        int      valid_cyc  = -1;
        int      low_left   = 0;
        int      waited     = 0;
        bit      want_high  = 1'b0;
        bit      done       = 1'b0;
        bit      prev_valid = 1'b0;
        bit      accept;
        int      n          = beats.size();
        longint  total      = 0;
        logic [ACC_W-1:0] exp_sum, prev_sum;
        logic [CNT_W-1:0] exp_cnt, prev_cnt;
        logic             exp_ovf, prev_ovf;

        foreach (beats[k]) total += longint'(beats[k]);
        exp_sum = total[ACC_W-1:0];
        exp_cnt = n[CNT_W-1:0];
        exp_ovf = (total >= (longint'(1) << ACC_W));
        prev_sum = '0;
        prev_cnt = '0;
        prev_ovf = 1'b0;

        check_val("idle_busy", 32'(busy), 32'd0);
        check_val("idle_ready", 32'(in_ready), 32'd1);

        while (!done && guard < 20000) begin
            guard++;
            if (low_left > 0) begin
                check_val("pass_stall_ready", 32'(in_ready), 32'd0);
                low_left--;
            end else if (want_high) begin
                check_val("pass_resume_ready", 32'(in_ready), 32'd1);
                want_high = 1'b0;
            end
            if (prev_valid) begin
                check_val("hold_valid", 32'(out_valid), 32'd1);
                check_val("hold_sum", 32'(out_sum), 32'(prev_sum));
                check_val("hold_count", 32'(out_count), 32'(prev_cnt));
                check_val("hold_ovf", 32'(out_ovf), 32'(prev_ovf));
            end
            if (out_valid) begin
                check_val("done_in_ready", 32'(in_ready), 32'd0);
                check_val("done_busy", 32'(busy), 32'd1);
                if (valid_cyc < 0) begin
                    valid_cyc = cyc;
                    check_val("latency", 32'(cyc - last_cyc), 32'd3);
                end
            end
            prev_valid = out_valid;
            prev_sum   = out_sum;
            prev_cnt   = out_count;
            prev_ovf   = out_ovf;

            if (in_ready && i < n) begin
                in_valid = ($urandom_range(99) >= in_stall);
                in_data  = 10'(beats[i]);
                in_last  = (i == n - 1);
            end else begin
                in_valid = in_ready ? 1'b0 : 1'($urandom_range(1));
                in_data  = 10'($urandom_range(1023));
                in_last  = 1'($urandom_range(1));
            end
            if (out_valid && waited < hold) begin
                out_ready = 1'b0;
                waited++;
            end else begin
                out_ready = ($urandom_range(99) >= out_stall);
            end

            if (out_valid && out_ready) begin
                check_val("sum", 32'(out_sum), 32'(exp_sum));
                check_val("count", 32'(out_count), 32'(exp_cnt));
                check_val("ovf", 32'(out_ovf), 32'(exp_ovf));
                done = 1'b1;
            end
            accept = in_valid && in_ready;

            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (accept) begin
                i++;
                pos++;
                if (i == n || pos == 8) begin
                    low_left  = 2;
                    want_high = (i != n);
                    pos       = 0;
                end
                if (i == n) last_cyc = cyc - 1;
            end
        end
        if (!done) check_val("result_timeout", 32'd0, 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic fill(input int len, input int val);
        beats.delete();
        for (int k = 0; k < len; k++) beats.push_back(val < 0 ? $urandom_range(1023) : val);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 10'd0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_in_ready", 32'(in_ready), 32'd0);
        check_val("rst_sum", 32'(out_sum), 32'd0);
        check_val("rst_count", 32'(out_count), 32'd0);
        check_val("rst_ovf", 32'(out_ovf), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // single operand
        fill(1, 5);     play(0, 0, 0);
        // eight full-scale operands resolve in one pass
        fill(8, 1023);  play(0, 0, 0);
        // nine operands: one full pass then a one-operand pass
        fill(9, 1);     play(0, 0, 0);
        // accumulator wraps and sets the sticky overflow
        fill(72, 1023); play(0, 0, 0);
        // consumer holds off for five cycles, then a fresh group starts from zero
        fill(4, -1);    play(0, 0, 5);
        beats.delete(); beats.push_back(7); beats.push_back(9);
        play(0, 0, 0);

        // reset in the middle of a three-operand group
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 10'(50 + k);
            in_last  = (k == 2);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check_val("abort_out_valid", 32'(out_valid), 32'd0);
        check_val("abort_in_ready", 32'(in_ready), 32'd0);
        check_val("abort_count", 32'(out_count), 32'd0);
        check_val("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        beats.delete(); beats.push_back(100); beats.push_back(200);
        play(0, 0, 0);

        // count wraps while the sum also overflows
        fill(260, 1023); play(10, 0, 0);

        for (int g = 0; g < 25; g++) begin
            fill($urandom_range(1, 40), -1);
            play($urandom_range(0, 50), $urandom_range(0, 60), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
